// File: rtl/bus_connect_if.sv
// Request, crossbar and DM handshake bundle for bus_connect.
// master = the transfer engine, slave = the PS/crossbar/DM side.
interface bus_connect_if #(
    parameter int RF_DATASIZE      = 16,
    parameter int DM_ADDRESS_WIDTH = 16,
    parameter int IMM_WIDTH        = 8
);
    logic                        ps_bc_ld;
    logic                        ps_bc_st;
    logic                        ps_bc_imm;
    logic                        ps_bc_sext;
    logic [DM_ADDRESS_WIDTH-1:0] ps_bc_add;
    logic [IMM_WIDTH-1:0]        ps_bc_immdt;
    logic [RF_DATASIZE-1:0]      xb_dtx;
    logic [RF_DATASIZE-1:0]      bc_dt;
    logic                        bc_xb_valid;
    logic                        bc_ps_stall;
    logic                        bc_ps_err;
    logic [DM_ADDRESS_WIDTH-1:0] bc_dm_add;
    logic                        bc_dm_rd;
    logic                        bc_dm_wr;
    logic [RF_DATASIZE-1:0]      bc_dm_wdt;
    logic                        dm_bc_ack;
    logic [RF_DATASIZE-1:0]      dm_bc_rdt;

    modport master (
        input  ps_bc_ld, ps_bc_st, ps_bc_imm, ps_bc_sext, ps_bc_add, ps_bc_immdt,
        input  xb_dtx, dm_bc_ack, dm_bc_rdt,
        output bc_dt, bc_xb_valid, bc_ps_stall, bc_ps_err,
        output bc_dm_add, bc_dm_rd, bc_dm_wr, bc_dm_wdt
    );

    modport slave (
        output ps_bc_ld, ps_bc_st, ps_bc_imm, ps_bc_sext, ps_bc_add, ps_bc_immdt,
        output xb_dtx, dm_bc_ack, dm_bc_rdt,
        input  bc_dt, bc_xb_valid, bc_ps_stall, bc_ps_err,
        input  bc_dm_add, bc_dm_rd, bc_dm_wr, bc_dm_wdt
    );
endinterface

// File: rtl/bus_connect.sv
// Registered transfer engine between the crossbar and data memory: DM load,
// DM store or immediate load, one per PS request, with a bounded DM wait.
//
// state   | meaning
// IDLE    | accepting requests (ld > st > imm)
// RD_WAIT | DM read outstanding, waiting for ack or timeout
// WR_WAIT | DM write outstanding, waiting for ack or timeout
module bus_connect #(
    parameter int RF_DATASIZE      = 16,
    parameter int DM_ADDRESS_WIDTH = 16,
    parameter int IMM_WIDTH        = 8,
    parameter int TIMEOUT          = 15
) (
    input  logic          clk_exe,
    input  logic          reset,
    bus_connect_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    state_t                      state_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [CNT_W-1:0]            cnt_inc_d;
    logic                        timeout_d;
    logic [RF_DATASIZE-1:0]      imm_ext_d;
    logic [RF_DATASIZE-1:0]      dt_q;
    logic [RF_DATASIZE-1:0]      wdt_q;
    logic [DM_ADDRESS_WIDTH-1:0] add_q;
    logic                        valid_q;
    logic                        stall_q;
    logic                        err_q;
    logic                        rd_q;
    logic                        wr_q;

    always_comb begin
        imm_ext_d = {RF_DATASIZE{bus.ps_bc_sext & bus.ps_bc_immdt[IMM_WIDTH-1]}};
        imm_ext_d[IMM_WIDTH-1:0] = bus.ps_bc_immdt;
    end

    // The abort fires on the edge that would bring the count to TIMEOUT.
    assign cnt_inc_d = cnt_q + CNT_W'(1);
    assign timeout_d = (cnt_inc_d == CNT_W'(TIMEOUT));

    always_ff @(posedge clk_exe) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dt_q    <= '0;
            wdt_q   <= '0;
            add_q   <= '0;
            valid_q <= 1'b0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.ps_bc_ld) begin
                        add_q   <= bus.ps_bc_add;
                        rd_q    <= 1'b1;
                        stall_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= RD_WAIT;
                    end else if (bus.ps_bc_st) begin
                        add_q   <= bus.ps_bc_add;
                        wdt_q   <= bus.xb_dtx;
                        wr_q    <= 1'b1;
                        stall_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= WR_WAIT;
                    end else if (bus.ps_bc_imm) begin
                        dt_q    <= imm_ext_d;
                        valid_q <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (bus.dm_bc_ack) begin
                        dt_q    <= bus.dm_bc_rdt;
                        valid_q <= 1'b1;
                        rd_q    <= 1'b0;
                        stall_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (timeout_d) begin
                        rd_q    <= 1'b0;
                        stall_q <= 1'b0;
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                WR_WAIT: begin
                    if (bus.dm_bc_ack) begin
                        wr_q    <= 1'b0;
                        stall_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (timeout_d) begin
                        wr_q    <= 1'b0;
                        stall_q <= 1'b0;
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                default: begin
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    stall_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.bc_dt       = dt_q;
    assign bus.bc_xb_valid = valid_q;
    assign bus.bc_ps_stall = stall_q;
    assign bus.bc_ps_err   = err_q;
    assign bus.bc_dm_add   = add_q;
    assign bus.bc_dm_rd    = rd_q;
    assign bus.bc_dm_wr    = wr_q;
    assign bus.bc_dm_wdt   = wdt_q;
endmodule

// File: tb/tb_bus_connect.sv
// Self-checking bench for bus_connect: directed PS/DM stimulus, with a
// scoreboard of expected data-valid and error pulses.
module tb_bus_connect;
    logic clk_exe = 1'b0;
    logic reset   = 1'b1;

    bus_connect_if #(.RF_DATASIZE(16), .DM_ADDRESS_WIDTH(16), .IMM_WIDTH(8)) bus ();

    bus_connect #(
        .RF_DATASIZE(16), .DM_ADDRESS_WIDTH(16), .IMM_WIDTH(8), .TIMEOUT(15)
    ) dut (
        .clk_exe(clk_exe),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_exe = ~clk_exe;

    typedef struct packed {
        logic        err;
        logic [15:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_exe);
        #1;
    endtask

    task automatic push_exp(input logic err, input logic [15:0] data);
        exp_t e;
        e.err  = err;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic clear_req();
        bus.ps_bc_ld  = 1'b0;
        bus.ps_bc_st  = 1'b0;
        bus.ps_bc_imm = 1'b0;
    endtask

    // Every valid or error pulse must match the head of the scoreboard.
    always @(negedge clk_exe) begin
        if (!reset && (bus.bc_xb_valid || bus.bc_ps_err)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, bus.bc_xb_valid, bus.bc_ps_err}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_err", {31'd0, bus.bc_ps_err}, {31'd0, e.err});
                chk("sb_valid", {31'd0, bus.bc_xb_valid}, {31'd0, ~e.err});
                if (!e.err) chk("sb_data", {16'd0, bus.bc_dt}, {16'd0, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_req();
        bus.ps_bc_sext   = 1'b0;
        bus.ps_bc_add    = '0;
        bus.ps_bc_immdt  = '0;
        bus.xb_dtx       = '0;
        bus.dm_bc_ack    = 1'b0;
        bus.dm_bc_rdt    = '0;

        // reset
        reset = 1'b1;
        tick(); tick();
        chk("rst_dt",    {16'd0, bus.bc_dt}, 32'd0);
        chk("rst_ctl",   {27'd0, bus.bc_xb_valid, bus.bc_ps_stall, bus.bc_ps_err,
                          bus.bc_dm_rd, bus.bc_dm_wr}, 32'd0);
        chk("rst_add",   {16'd0, bus.bc_dm_add}, 32'd0);
        chk("rst_wdt",   {16'd0, bus.bc_dm_wdt}, 32'd0);
        reset = 1'b0;
        tick();

        // back-to-back immediates: sign then zero extension
        bus.ps_bc_imm = 1'b1; bus.ps_bc_immdt = 8'hF3; bus.ps_bc_sext = 1'b1;
        push_exp(1'b0, 16'hFFF3);
        tick();
        chk("imm_sext_dt", {16'd0, bus.bc_dt}, 32'h0000_FFF3);
        chk("imm_nostall", {31'd0, bus.bc_ps_stall}, 32'd0);
        bus.ps_bc_sext = 1'b0;
        push_exp(1'b0, 16'h00F3);
        tick();
        chk("imm_zext_dt", {16'd0, bus.bc_dt}, 32'h0000_00F3);
        chk("imm_b2b_valid", {31'd0, bus.bc_xb_valid}, 32'd1);
        clear_req();
        tick();
        chk("imm_valid_end", {31'd0, bus.bc_xb_valid}, 32'd0);
        chk("imm_dt_hold", {16'd0, bus.bc_dt}, 32'h0000_00F3);

        // load with ack on the third wait edge
        bus.ps_bc_ld = 1'b1; bus.ps_bc_add = 16'h0040;
        push_exp(1'b0, 16'hBEEF);
        tick();
        clear_req();
        for (int i = 0; i < 3; i++) begin
            chk("ld_rd",    {31'd0, bus.bc_dm_rd}, 32'd1);
            chk("ld_add",   {16'd0, bus.bc_dm_add}, 32'h0000_0040);
            chk("ld_stall", {31'd0, bus.bc_ps_stall}, 32'd1);
            if (i == 2) begin
                bus.dm_bc_ack = 1'b1; bus.dm_bc_rdt = 16'hBEEF;
            end
            tick();
        end
        bus.dm_bc_ack = 1'b0;
        chk("ld_done_rd",    {31'd0, bus.bc_dm_rd}, 32'd0);
        chk("ld_done_stall", {31'd0, bus.bc_ps_stall}, 32'd0);
        tick();

        // store: write data sampled at acceptance, ack after one cycle
        bus.ps_bc_st = 1'b1; bus.ps_bc_add = 16'h0080; bus.xb_dtx = 16'h1234;
        tick();
        clear_req();
        bus.xb_dtx = 16'h5555;
        chk("st_wr",    {31'd0, bus.bc_dm_wr}, 32'd1);
        chk("st_add",   {16'd0, bus.bc_dm_add}, 32'h0000_0080);
        chk("st_stall", {31'd0, bus.bc_ps_stall}, 32'd1);
        tick();
        chk("st_wdt_hold", {16'd0, bus.bc_dm_wdt}, 32'h0000_1234);
        bus.dm_bc_ack = 1'b1;
        tick();
        bus.dm_bc_ack = 1'b0;
        chk("st_done_wr",    {31'd0, bus.bc_dm_wr}, 32'd0);
        chk("st_done_stall", {31'd0, bus.bc_ps_stall}, 32'd0);
        chk("st_dt_hold",    {16'd0, bus.bc_dt}, 32'h0000_BEEF);
        tick();

        // load timeout: 15 wait edges without ack
        bus.ps_bc_ld = 1'b1; bus.ps_bc_add = 16'h0011;
        push_exp(1'b1, 16'h0000);
        tick();
        clear_req();
        for (int i = 1; i < 15; i++) begin
            tick();
            chk("to_wait_stall", {31'd0, bus.bc_ps_stall}, 32'd1);
            chk("to_wait_err",   {31'd0, bus.bc_ps_err}, 32'd0);
        end
        tick();
        chk("to_err",   {31'd0, bus.bc_ps_err}, 32'd1);
        chk("to_stall", {31'd0, bus.bc_ps_stall}, 32'd0);
        chk("to_rd",    {31'd0, bus.bc_dm_rd}, 32'd0);
        chk("to_dt",    {16'd0, bus.bc_dt}, 32'h0000_BEEF);
        tick();
        chk("to_err_pulse", {31'd0, bus.bc_ps_err}, 32'd0);

        // ack on the 15th wait edge wins over timeout
        bus.ps_bc_ld = 1'b1; bus.ps_bc_add = 16'h0022;
        push_exp(1'b0, 16'hCAFE);
        tick();
        clear_req();
        for (int i = 1; i < 15; i++) tick();
        bus.dm_bc_ack = 1'b1; bus.dm_bc_rdt = 16'hCAFE;
        tick();
        bus.dm_bc_ack = 1'b0;
        chk("tob_err",   {31'd0, bus.bc_ps_err}, 32'd0);
        chk("tob_dt",    {16'd0, bus.bc_dt}, 32'h0000_CAFE);
        chk("tob_stall", {31'd0, bus.bc_ps_stall}, 32'd0);
        tick();

        // priority: ld wins over st and imm
        bus.ps_bc_ld = 1'b1; bus.ps_bc_st = 1'b1; bus.ps_bc_imm = 1'b1;
        bus.ps_bc_add = 16'h0033; bus.ps_bc_immdt = 8'h7F; bus.xb_dtx = 16'h9999;
        push_exp(1'b0, 16'h0A0A);
        tick();
        clear_req();
        chk("pri_rd", {31'd0, bus.bc_dm_rd}, 32'd1);
        chk("pri_wr", {31'd0, bus.bc_dm_wr}, 32'd0);
        chk("pri_wdt", {16'd0, bus.bc_dm_wdt}, 32'h0000_1234);
        bus.dm_bc_ack = 1'b1; bus.dm_bc_rdt = 16'h0A0A;
        tick();
        chk("pri_dt", {16'd0, bus.bc_dt}, 32'h0000_0A0A);
        // ack while idle must be ignored
        bus.dm_bc_rdt = 16'hFFFF;
        tick();
        bus.dm_bc_ack = 1'b0;
        chk("idle_ack_dt",    {16'd0, bus.bc_dt}, 32'h0000_0A0A);
        chk("idle_ack_valid", {31'd0, bus.bc_xb_valid}, 32'd0);
        chk("idle_ack_ctl",   {29'd0, bus.bc_ps_stall, bus.bc_dm_rd, bus.bc_dm_wr}, 32'd0);
        tick();

        // reset in the middle of a read
        bus.ps_bc_ld = 1'b1; bus.ps_bc_add = 16'h0044;
        tick();
        clear_req();
        tick();
        chk("mid_rd_before", {31'd0, bus.bc_dm_rd}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_ctl", {27'd0, bus.bc_xb_valid, bus.bc_ps_stall, bus.bc_ps_err,
                            bus.bc_dm_rd, bus.bc_dm_wr}, 32'd0);
        chk("mid_rst_dt", {16'd0, bus.bc_dt}, 32'd0);
        bus.ps_bc_ld = 1'b1; bus.ps_bc_add = 16'h0055;
        push_exp(1'b0, 16'h1357);
        tick();
        clear_req();
        chk("post_rst_add", {16'd0, bus.bc_dm_add}, 32'h0000_0055);
        bus.dm_bc_ack = 1'b1; bus.dm_bc_rdt = 16'h1357;
        tick();
        bus.dm_bc_ack = 1'b0;
        chk("post_rst_dt", {16'd0, bus.bc_dt}, 32'h0000_1357);
        for (int i = 0; i < 20; i++) tick();
        @(negedge clk_exe);
        #1;
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
